// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two private result FIFOs (ALU, LSB) drained round-robin onto a
// registered common data bus, one broadcast per cycle. Rollback flushes both
// FIFOs; reset does the same and also clears the bus outputs.
module cdb_arbiter #(
  parameter int WORD_W     = 32,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rollback_in,
  input  logic              alu_valid_in,
  output logic              alu_ready_out,
  input  logic [WORD_W-1:0] alu_result_in,
  input  logic [TAG_W-1:0]  alu_tag_in,
  input  logic [WORD_W-1:0] alu_new_pc_in,
  input  logic              lsb_valid_in,
  output logic              lsb_ready_out,
  input  logic [WORD_W-1:0] lsb_result_in,
  input  logic [TAG_W-1:0]  lsb_tag_in,
  output logic              cdb_valid_out,
  output logic [WORD_W-1:0] cdb_result_out,
  output logic [TAG_W-1:0]  cdb_tag_out,
  output logic [WORD_W-1:0] cdb_new_pc_out,
  output logic              cdb_src_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSB = 1'b1
  } req_e;

  typedef struct packed {
    logic [WORD_W-1:0] result;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] new_pc;
  } alu_entry_t;

  typedef struct packed {
    logic [WORD_W-1:0] result;
    logic [TAG_W-1:0]  tag;
  } lsb_entry_t;

  // FIFO storage
  alu_entry_t alu_mem_q [FIFO_DEPTH];
  lsb_entry_t lsb_mem_q [FIFO_DEPTH];

  // FIFO bookkeeping
  logic [PTR_W-1:0] alu_head_q, alu_head_d, alu_tail_q, alu_tail_d;
  logic [PTR_W-1:0] lsb_head_q, lsb_head_d, lsb_tail_q, lsb_tail_d;
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  req_e             last_grant_q, last_grant_d;

  // Bus registers
  logic              cdb_valid_q, cdb_valid_d;
  logic [WORD_W-1:0] cdb_result_q, cdb_result_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [WORD_W-1:0] cdb_new_pc_q, cdb_new_pc_d;
  req_e              cdb_src_q, cdb_src_d;

  logic alu_push, lsb_push;
  logic alu_grant, lsb_grant;
  logic alu_nonempty, lsb_nonempty;

  // Handshake, null-tag filtering and round-robin grant from start-of-cycle counts
  always_comb begin
    alu_ready_out = (alu_cnt_q != FULL_CNT) && !rollback_in && !rst;
    lsb_ready_out = (lsb_cnt_q != FULL_CNT) && !rollback_in && !rst;
    alu_push      = alu_valid_in && alu_ready_out && (alu_tag_in != '0);
    lsb_push      = lsb_valid_in && lsb_ready_out && (lsb_tag_in != '0);
    alu_nonempty  = (alu_cnt_q != '0);
    lsb_nonempty  = (lsb_cnt_q != '0);
    alu_grant     = alu_nonempty && (!lsb_nonempty || (last_grant_q == REQ_LSB));
    lsb_grant     = lsb_nonempty && !alu_grant;
  end

  // Next-state: reset, then rollback, then normal enqueue/dequeue/broadcast
  always_comb begin
    alu_head_d   = alu_head_q;
    alu_tail_d   = alu_tail_q;
    alu_cnt_d    = alu_cnt_q;
    lsb_head_d   = lsb_head_q;
    lsb_tail_d   = lsb_tail_q;
    lsb_cnt_d    = lsb_cnt_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = 1'b0;
    cdb_result_d = cdb_result_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_new_pc_d = cdb_new_pc_q;
    cdb_src_d    = cdb_src_q;

    // NOTE: reset is synchronous, so it is just the highest-priority branch of
    // the next-state logic; the state registers below need no reset term.
    if (rst) begin
      alu_head_d   = '0;
      alu_tail_d   = '0;
      alu_cnt_d    = '0;
      lsb_head_d   = '0;
      lsb_tail_d   = '0;
      lsb_cnt_d    = '0;
      last_grant_d = REQ_LSB;
      cdb_result_d = '0;
      cdb_tag_d    = '0;
      cdb_new_pc_d = '0;
      cdb_src_d    = REQ_ALU;
    end else if (rollback_in) begin
      alu_head_d = '0;
      alu_tail_d = '0;
      alu_cnt_d  = '0;
      lsb_head_d = '0;
      lsb_tail_d = '0;
      lsb_cnt_d  = '0;
    end else begin
      if (alu_push) alu_tail_d = alu_tail_q + PTR_ONE;
      if (lsb_push) lsb_tail_d = lsb_tail_q + PTR_ONE;
      if (alu_grant) alu_head_d = alu_head_q + PTR_ONE;
      if (lsb_grant) lsb_head_d = lsb_head_q + PTR_ONE;
      alu_cnt_d = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(alu_grant);
      lsb_cnt_d = lsb_cnt_q + CNT_W'(lsb_push) - CNT_W'(lsb_grant);

      if (alu_grant) begin
        cdb_valid_d  = 1'b1;
        cdb_result_d = alu_mem_q[alu_head_q].result;
        cdb_tag_d    = alu_mem_q[alu_head_q].tag;
        cdb_new_pc_d = alu_mem_q[alu_head_q].new_pc;
        cdb_src_d    = REQ_ALU;
        last_grant_d = REQ_ALU;
      end else if (lsb_grant) begin
        cdb_valid_d  = 1'b1;
        cdb_result_d = lsb_mem_q[lsb_head_q].result;
        cdb_tag_d    = lsb_mem_q[lsb_head_q].tag;
        cdb_new_pc_d = '0;
        cdb_src_d    = REQ_LSB;
        last_grant_d = REQ_LSB;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    alu_head_q   <= alu_head_d;
    alu_tail_q   <= alu_tail_d;
    alu_cnt_q    <= alu_cnt_d;
    lsb_head_q   <= lsb_head_d;
    lsb_tail_q   <= lsb_tail_d;
    lsb_cnt_q    <= lsb_cnt_d;
    last_grant_q <= last_grant_d;
    cdb_valid_q  <= cdb_valid_d;
    cdb_result_q <= cdb_result_d;
    cdb_tag_q    <= cdb_tag_d;
    cdb_new_pc_q <= cdb_new_pc_d;
    cdb_src_q    <= cdb_src_d;
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; counts and pointers define which
    // entries are live, so stale contents are never observed.
    if (alu_push) alu_mem_q[alu_tail_q] <= '{result: alu_result_in, tag: alu_tag_in,
                                            new_pc: alu_new_pc_in};
    if (lsb_push) lsb_mem_q[lsb_tail_q] <= '{result: lsb_result_in, tag: lsb_tag_in};
  end

  assign cdb_valid_out  = cdb_valid_q;
  assign cdb_result_out = cdb_result_q;
  assign cdb_tag_out    = cdb_tag_q;
  assign cdb_new_pc_out = cdb_new_pc_q;
  assign cdb_src_out    = cdb_src_q;

endmodule
